// File: rtl/key_debounce_capture_if.sv
// Key conditioner signal bundle: raw pins and clear in, debounced level, strobes and
// sticky capture flags out.
interface key_debounce_capture_if #(
    parameter int unsigned NUM_KEYS = 4
);
    logic [NUM_KEYS-1:0] key_raw;
    logic [NUM_KEYS-1:0] edge_clear;
    logic [NUM_KEYS-1:0] keys_export;
    logic [NUM_KEYS-1:0] press_pulse;
    logic [NUM_KEYS-1:0] edge_capture;

    // Board/system side: drives the pins and the clear, observes the conditioned outputs.
    modport master (
        output key_raw,
        output edge_clear,
        input  keys_export,
        input  press_pulse,
        input  edge_capture
    );

    // Conditioner side.
    modport slave (
        input  key_raw,
        input  edge_clear,
        output keys_export,
        output press_pulse,
        output edge_capture
    );
endinterface

// File: rtl/key_debounce_capture.sv
// Pushbutton conditioner: 2-flop synchroniser, per-key debounce FSM, registered press
// strobe and sticky per-key press capture with synchronous per-bit clear.
module key_debounce_capture #(
    parameter int unsigned NUM_KEYS        = 4,
    parameter int unsigned DEBOUNCE_CYCLES = 500000,
    parameter bit          ACTIVE_LOW      = 1'b1
) (
    input logic                    clk_clk,
    input logic                    reset_reset,
    key_debounce_capture_if.slave  keys
);

    localparam int unsigned CNT_W     = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic        ACT_LVL   = ACTIVE_LOW ? 1'b0 : 1'b1;
    localparam logic        INACT_LVL = ~ACT_LVL;

    typedef enum logic {
        StStable,
        StCounting
    } state_t;

    logic [NUM_KEYS-1:0] sync1_q;
    logic [NUM_KEYS-1:0] sync2_q;
    logic [NUM_KEYS-1:0] level_vec;
    logic [NUM_KEYS-1:0] pulse_vec;
    logic [NUM_KEYS-1:0] cap_vec;

    // Two-flop synchroniser; flops reset to the released level so no spurious press.
    always_ff @(posedge clk_clk or posedge reset_reset) begin
        if (reset_reset) begin
            sync1_q <= {NUM_KEYS{INACT_LVL}};
            sync2_q <= {NUM_KEYS{INACT_LVL}};
        end else begin
            sync1_q <= keys.key_raw;
            sync2_q <= sync1_q;
        end
    end

    for (genvar i = 0; i < NUM_KEYS; i++) begin : g_key
        state_t           state_q;
        logic [CNT_W-1:0] cnt_q;
        logic             level_q;
        logic             pulse_q;
        logic             cap_q;
        logic             differs;
        logic             accept;
        logic             press_now;

        // cnt_q holds the number of differing observations already seen; the current
        // observation is the (cnt_q+1)-th, and the DEBOUNCE_CYCLES-th one is accepted.
        always_comb begin
            differs   = (sync2_q[i] != level_q);
            accept    = 1'b0;
            if (differs) begin
                if (state_q == StStable) begin
                    accept = (DEBOUNCE_CYCLES == 1);
                end else begin
                    accept = (cnt_q == CNT_W'(DEBOUNCE_CYCLES - 1));
                end
            end
            press_now = accept && (sync2_q[i] == ACT_LVL);
        end

        // Debounce FSM with registered level, press strobe and sticky capture.
        always_ff @(posedge clk_clk or posedge reset_reset) begin
            if (reset_reset) begin
                state_q <= StStable;
                cnt_q   <= '0;
                level_q <= INACT_LVL;
                pulse_q <= 1'b0;
                cap_q   <= 1'b0;
            end else begin
                pulse_q <= press_now;
                // Set wins over clear so a press landing on a clear is never lost.
                cap_q   <= (cap_q && !keys.edge_clear[i]) || press_now;
                unique case (state_q)
                    StStable: begin
                        if (differs) begin
                            if (accept) begin
                                level_q <= sync2_q[i];
                                cnt_q   <= '0;
                            end else begin
                                state_q <= StCounting;
                                cnt_q   <= CNT_W'(1);
                            end
                        end else begin
                            cnt_q <= '0;
                        end
                    end
                    StCounting: begin
                        if (!differs) begin
                            // Bounced back before acceptance: drop the attempt.
                            state_q <= StStable;
                            cnt_q   <= '0;
                        end else if (accept) begin
                            level_q <= sync2_q[i];
                            state_q <= StStable;
                            cnt_q   <= '0;
                        end else begin
                            cnt_q <= cnt_q + CNT_W'(1);
                        end
                    end
                    default: begin
                        state_q <= StStable;
                        cnt_q   <= '0;
                    end
                endcase
            end
        end

        assign level_vec[i] = level_q;
        assign pulse_vec[i] = pulse_q;
        assign cap_vec[i]   = cap_q;
    end

    assign keys.keys_export  = level_vec;
    assign keys.press_pulse  = pulse_vec;
    assign keys.edge_capture = cap_vec;

endmodule

// File: tb/tb_key_debounce_capture.sv
// Directed bench for key_debounce_capture with NUM_KEYS=4, DEBOUNCE_CYCLES=8, ACTIVE_LOW=1.
module tb_key_debounce_capture;

    logic clk;
    logic rst;
    int   checks;
    int   errors;
    int   npulse;

    key_debounce_capture_if #(.NUM_KEYS(4)) kif ();

    key_debounce_capture #(
        .NUM_KEYS       (4),
        .DEBOUNCE_CYCLES(8),
        .ACTIVE_LOW     (1'b1)
    ) dut (
        .clk_clk    (clk),
        .reset_reset(rst),
        .keys       (kif)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One clock edge, then sample 1 ns later; counts any press strobe seen.
    task automatic step();
        @(posedge clk);
        #1;
        if (|kif.press_pulse) npulse++;
    endtask

    initial begin
        checks         = 0;
        errors         = 0;
        npulse         = 0;
        rst            = 1'b1;
        kif.key_raw    = 4'hF;
        kif.edge_clear = 4'h0;

        // 1. Reset state.
        #2;
        chk("rst_export", kif.keys_export, 4'hF);
        chk("rst_pulse", kif.press_pulse, 4'h0);
        chk("rst_capture", kif.edge_capture, 4'h0);
        step();
        step();
        @(negedge clk);
        rst = 1'b0;
        repeat (3) step();
        chk("idle_export", kif.keys_export, 4'hF);

        // 2. Key 0 pressed cleanly: accepted at E+9.
        kif.key_raw = 4'hE;
        npulse = 0;
        repeat (9) step();
        chk("k0_export_e8", kif.keys_export, 4'hF);
        chk("k0_nopulse_e8", npulse, 0);
        step();
        chk("k0_export_e9", kif.keys_export, 4'hE);
        chk("k0_pulse_e9", kif.press_pulse, 4'h1);
        chk("k0_capture_e9", kif.edge_capture, 4'h1);
        step();
        chk("k0_pulse_e10", kif.press_pulse, 4'h0);
        chk("k0_capture_e10", kif.edge_capture, 4'h1);

        // 4a. One-cycle clear.
        kif.edge_clear = 4'h1;
        step();
        kif.edge_clear = 4'h0;
        chk("clear_k0", kif.edge_capture, 4'h0);

        // 3. Key 1 bounces every 3 cycles for 30 cycles, then settles pressed.
        npulse = 0;
        for (int t = 0; t < 10; t++) begin
            kif.key_raw[1] = ~kif.key_raw[1];
            repeat (3) step();
            chk("bounce_export", kif.keys_export, 4'hE);
        end
        chk("bounce_nopulse", npulse, 0);
        kif.key_raw[1] = 1'b0;
        repeat (9) step();
        chk("k1_export_e8", kif.keys_export, 4'hE);
        chk("k1_nopulse_e8", npulse, 0);
        step();
        chk("k1_export_e9", kif.keys_export, 4'hC);
        chk("k1_pulse_e9", kif.press_pulse, 4'h2);
        chk("k1_capture", kif.edge_capture, 4'h2);

        // 4b. Clear of key 2 on the very edge its press is accepted: set wins.
        kif.key_raw = 4'h8;
        repeat (9) step();
        kif.edge_clear = 4'h4;
        step();
        kif.edge_clear = 4'h0;
        chk("k2_pulse", kif.press_pulse, 4'h4);
        chk("k2_set_wins", kif.edge_capture, 4'h6);
        kif.edge_clear = 4'h6;
        step();
        kif.edge_clear = 4'h0;
        chk("clear_k1k2", kif.edge_capture, 4'h0);

        // Release everything; releases never pulse.
        kif.key_raw = 4'hF;
        npulse = 0;
        repeat (12) step();
        chk("release_all_export", kif.keys_export, 4'hF);
        chk("release_all_nopulse", npulse, 0);
        chk("release_all_capture", kif.edge_capture, 4'h0);

        // 5. Keys 2 and 3 pressed together, held 20 cycles, then released.
        kif.key_raw = 4'h3;
        repeat (9) step();
        chk("k23_export_e8", kif.keys_export, 4'hF);
        step();
        chk("k23_export_e9", kif.keys_export, 4'h3);
        chk("k23_pulse", kif.press_pulse, 4'hC);
        step();
        chk("k23_pulse_off", kif.press_pulse, 4'h0);
        chk("k23_capture", kif.edge_capture, 4'hC);
        repeat (9) step();
        kif.key_raw = 4'hF;
        npulse = 0;
        repeat (9) step();
        chk("k23_rel_e8", kif.keys_export, 4'h3);
        step();
        chk("k23_rel_e9", kif.keys_export, 4'hF);
        step();
        chk("k23_rel_nopulse", npulse, 0);

        // 6. Key 0 held low, reset asserted asynchronously mid-count (cnt=5).
        kif.key_raw = 4'hE;
        repeat (7) step();
        rst = 1'b1;
        #1;
        chk("async_rst_export", kif.keys_export, 4'hF);
        chk("async_rst_pulse", kif.press_pulse, 4'h0);
        chk("async_rst_capture", kif.edge_capture, 4'h0);
        step();
        step();
        chk("held_rst_export", kif.keys_export, 4'hF);
        @(negedge clk);
        rst = 1'b0;
        npulse = 0;
        repeat (9) step();
        chk("post_rst_nopulse_e8", npulse, 0);
        chk("post_rst_export_e8", kif.keys_export, 4'hF);
        step();
        chk("post_rst_pulse", kif.press_pulse, 4'h1);
        chk("post_rst_export", kif.keys_export, 4'hE);
        npulse = 0;
        repeat (5) step();
        chk("post_rst_single", npulse, 0);
        chk("post_rst_capture", kif.edge_capture, 4'h1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
